// File: rtl/cell_input_sequencer_pkg.sv
// Shared definitions for the cell input sequencer: default sizes and the
// debounce/commit FSM state encoding.
package cell_input_sequencer_pkg;

    localparam int WIDTH_DEF           = 6;
    localparam int NUM_PAGES_DEF       = 48;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cell_input_sequencer_debouncer.sv
// Synchronises the raw {mode, switches} word and accepts it once it has been
// sampled unchanged for DEBOUNCE_CYCLES consecutive cycles.
module cell_input_sequencer_debouncer
    import cell_input_sequencer_pkg::*;
#(
    parameter int W               = WIDTH_DEF + 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic         stable,
    output logic [W-1:0] word,
    output seq_state_t   state
);

    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [W-1:0] sync_meta;
    logic [W-1:0] sample;
    logic [W-1:0] cand, cand_next;
    logic [W-1:0] last_word, last_word_next;
    logic [7:0]   count, count_next;
    seq_state_t   state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sample    <= '0;
            cand      <= '0;
            last_word <= '0;
            count     <= '0;
            state     <= ST_IDLE;
        end else begin
            sync_meta <= raw;
            sample    <= sync_meta;
            cand      <= cand_next;
            last_word <= last_word_next;
            count     <= count_next;
            state     <= state_next;
        end
    end

    // SETTLE lasts exactly DEBOUNCE_CYCLES cycles on a clean input; the
    // counter stops at the limit so it can never wrap.
    always_comb begin
        state_next     = state;
        cand_next      = cand;
        count_next     = count;
        last_word_next = last_word;
        case (state)
            ST_IDLE: begin
                if (sample != last_word) begin
                    cand_next  = sample;
                    count_next = 8'd1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sample != cand) begin
                    cand_next  = sample;
                    count_next = 8'd1;
                end else if (count >= DEB_LIMIT) begin
                    state_next = ST_COMMIT;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            ST_COMMIT: begin
                // Remember the word even if the top rejects it, so a held
                // out-of-range value does not retrigger forever.
                last_word_next = cand;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign stable = (state == ST_COMMIT);
    assign word   = cand;

endmodule

// File: rtl/cell_input_sequencer.sv
// Commits debounced switch values into the page-select or cell-input register
// and strobes update whenever either register actually changes.
module cell_input_sequencer
    import cell_input_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int NUM_PAGES       = NUM_PAGES_DEF,
    parameter int WIDTH           = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             page_mode,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] page,
    output logic [WIDTH-1:0] cell_in,
    output logic             update,
    output logic             page_err,
    output logic             busy
);

    localparam logic [WIDTH:0] PAGE_LIMIT = (WIDTH + 1)'(NUM_PAGES);

    logic           stable;
    logic [WIDTH:0] word;
    seq_state_t     deb_state;
    logic           word_mode;
    logic [WIDTH-1:0] word_value;

    cell_input_sequencer_debouncer #(
        .W               (WIDTH + 1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .raw    ({page_mode, switches}),
        .stable (stable),
        .word   (word),
        .state  (deb_state)
    );

    assign word_mode  = word[WIDTH];
    assign word_value = word[WIDTH-1:0];
    assign busy       = (deb_state != ST_IDLE);

    // Outputs are registered on the commit cycle so update and the new value
    // become visible together.
    always_ff @(posedge clk) begin
        if (reset) begin
            page     <= '0;
            cell_in  <= '0;
            update   <= 1'b0;
            page_err <= 1'b0;
        end else begin
            update <= 1'b0;
            if (stable) begin
                if (word_mode) begin
                    if ({1'b0, word_value} < PAGE_LIMIT) begin
                        page_err <= 1'b0;
                        if (word_value != page) begin
                            page   <= word_value;
                            update <= 1'b1;
                        end
                    end else begin
                        page_err <= 1'b1;
                    end
                end else if (word_value != cell_in) begin
                    cell_in <= word_value;
                    update  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_input_sequencer.sv
// Self-checking bench for cell_input_sequencer with default parameters (D=4).
module tb_cell_input_sequencer;

    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       page_mode = 1'b0;
    logic [5:0] switches = 6'h00;
    logic [5:0] page;
    logic [5:0] cell_in;
    logic       update;
    logic       page_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Expected {page, cell_in, page_err} after each commit that strobes update.
    logic [12:0] exp_q[$];

    logic [5:0] m_page;
    logic [5:0] m_cell;
    logic       m_err;
    logic [6:0] m_last;

    cell_input_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .page_mode (page_mode),
        .switches  (switches),
        .page      (page),
        .cell_in   (cell_in),
        .update    (update),
        .page_err  (page_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_page = 6'd0;
        m_cell = 6'd0;
        m_err  = 1'b0;
        m_last = 7'd0;
    endtask

    task automatic drive(input logic mode, input logic [5:0] sw);
        @(negedge clk);
        page_mode = mode;
        switches  = sw;
    endtask

    task automatic expect_commit(input int exp_lat, input string name);
        int lat;
        logic [12:0] e;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected %0d (0 = no update)", name, lat, exp_lat);
        end
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            if (lat != 0) begin
                n_cmp++;
                if ({page, cell_in, page_err} !== e) begin
                    n_err++;
                    $display("FAIL %s outputs: got page=%0d cell_in=%0d err=%b, expected page=%0d cell_in=%0d err=%b",
                             name, page, cell_in, page_err, e[12:7], e[6:1], e[0]);
                end
                @(negedge clk);
                n_cmp++;
                if (update !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s pulse width: update=%b one cycle later, expected 0", name, update);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy after commit: got %b expected 0", name, busy);
        end
    endtask

    // Drives one stable input word and checks the result against the model.
    task automatic apply(input logic mode, input logic [5:0] sw, input string name);
        logic upd;
        logic seen;
        upd = 1'b0;
        if ({mode, sw} != m_last) begin
            m_last = {mode, sw};
            if (mode) begin
                if (sw < 6'd48) begin
                    m_err = 1'b0;
                    if (sw != m_page) begin
                        m_page = sw;
                        upd = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end else if (sw != m_cell) begin
                m_cell = sw;
                upd = 1'b1;
            end
        end
        drive(mode, sw);
        if (upd) begin
            exp_q.push_back({m_page, m_cell, m_err});
            expect_commit(LAT, name);
        end else begin
            seen = 1'b0;
            repeat (LAT + 4) begin
                @(negedge clk);
                if (update !== 1'b0) seen = 1'b1;
            end
            n_cmp++;
            if (seen !== 1'b0) begin
                n_err++;
                $display("FAIL %s spurious update: got update, expected none", name);
            end
            n_cmp++;
            if ({page, cell_in, page_err} !== {m_page, m_cell, m_err}) begin
                n_err++;
                $display("FAIL %s held outputs: got page=%0d cell_in=%0d err=%b, expected page=%0d cell_in=%0d err=%b",
                         name, page, cell_in, page_err, m_page, m_cell, m_err);
            end
        end
    endtask

    task automatic test_reset();
        logic seen;
        reset     = 1'b1;
        page_mode = 1'b0;
        switches  = 6'h2A;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({page, cell_in, update, page_err, busy} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_values: got page=%0d cell_in=%0d upd=%b err=%b busy=%b, expected all 0",
                     page, cell_in, update, page_err, busy);
        end
        reset    = 1'b0;
        switches = 6'h00;
        model_reset();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (update !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got update/busy activity, expected none");
        end
        n_cmp++;
        if ({page, cell_in, page_err} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_idle_outputs: got page=%0d cell_in=%0d err=%b, expected 0", page, cell_in, page_err);
        end
    endtask

    task automatic test_clean_load();
        apply(1'b0, 6'h15, "clean_load");
    endtask

    task automatic test_bounce();
        logic seen;
        logic busy_low;
        seen = 1'b0;
        busy_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, (i % 2 == 0) ? 6'h07 : 6'h00);
            @(negedge clk);
            if (update !== 1'b0) seen = 1'b1;
            if (i > 1 && busy !== 1'b1) busy_low = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_no_commit: got update during bouncing, expected none");
        end
        n_cmp++;
        if (busy_low !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_busy: got busy=0 while bouncing, expected 1");
        end
        apply(1'b0, 6'h07, "bounce_final");
    endtask

    task automatic test_page_range();
        apply(1'b1, 6'd47, "page_47");
        apply(1'b1, 6'd50, "page_50_reject");
        apply(1'b1, 6'd47, "page_47_same");
        apply(1'b1, 6'd50, "page_50_again");
        apply(1'b1, 6'd3,  "page_3");
    endtask

    task automatic test_mode_toggle();
        apply(1'b0, 6'h09, "toggle_cell");
        apply(1'b1, 6'h09, "toggle_page");
    endtask

    task automatic test_reset_mid();
        logic bad;
        drive(1'b0, 6'h3F);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_settle_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if ({page, cell_in, update, page_err, busy} !== 15'd0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got page=%0d cell_in=%0d upd=%b err=%b busy=%b, expected all 0",
                     page, cell_in, update, page_err, busy);
        end
        reset = 1'b0;
        model_reset();
        m_last = {1'b0, 6'h3F};
        m_cell = 6'h3F;
        exp_q.push_back({m_page, m_cell, m_err});
        expect_commit(LAT, "post_reset_commit");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            apply(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_load();
        test_bounce();
        test_page_range();
        test_mode_toggle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
